// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and
// the counter width calculation used by the top level.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  // Width needed to count up to the larger of the hold and stagger intervals.
  function automatic int cnt_width(input int hold, input int stagger);
    int m;
    m = (hold > stagger) ? hold : stagger;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_sync.sv
// Reset synchroniser: asynchronous assertion, synchronous deassertion.
// The output stays high until STAGES rising edges have seen rst_i low.
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic sync_rst_o
);

  logic [STAGES-1:0] sync_d;
  logic [STAGES-1:0] sync_q;

  // Shift a zero into the chain every cycle once rst_i is low.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], 1'b0};
  end

  // Chain flops: set to all ones while rst_i is high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_rst_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer top: holds all domain resets for HOLD_CYCLES after the
// synchronised deassertion of rst_i, then releases the NUM_CH active-low
// domain resets one by one, STAGGER_CYCLES apart, and raises done_o.
// Optional feature macro: RESET_SEQ_SWRST_EN adds the sw_rst_i port, which
// restarts the whole hold/release sequence while sampled high.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
`ifdef RESET_SEQ_SWRST_EN
  input  logic              sw_rst_i,
`endif
  output logic [NUM_CH-1:0] rst_no,
  output logic              done_o
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGGER_CYCLES);
  localparam int CH_W  = $clog2(NUM_CH + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);

  logic              sync_rst;
  logic              sw_req;
  state_e            state_d,  state_q;
  logic [CNT_W-1:0]  cnt_d,    cnt_q;
  logic [CH_W-1:0]   ch_idx_d, ch_idx_q;
  logic [NUM_CH-1:0] rst_no_d, rst_no_q;
  logic              done_d,   done_q;

  reset_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .sync_rst_o (sync_rst)
  );

`ifdef RESET_SEQ_SWRST_EN
  assign sw_req = sw_rst_i;
`else
  assign sw_req = 1'b0;
`endif

  // Next-state logic: restart on any reset request, otherwise count and release in order.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ch_idx_d = ch_idx_q;
    rst_no_d = rst_no_q;
    done_d   = done_q;
    if (sync_rst || sw_req) begin
      state_d  = HOLD;
      cnt_d    = '0;
      ch_idx_d = '0;
      rst_no_d = '0;
      done_d   = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q >= HOLD_LAST) begin
            rst_no_d[0] = 1'b1;
            cnt_d       = '0;
            if (NUM_CH == 1) begin
              state_d  = RUN;
              done_d   = 1'b1;
              ch_idx_d = '0;
            end else begin
              state_d  = RELEASE;
              ch_idx_d = CH_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_q >= STAG_LAST) begin
            cnt_d = '0;
            for (int i = 0; i < NUM_CH; i++) begin
              if (CH_W'(i) == ch_idx_q) begin
                rst_no_d[i] = 1'b1;
              end else begin
                rst_no_d[i] = rst_no_q[i];
              end
            end
            if (ch_idx_q >= LAST_CH) begin
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              ch_idx_d = ch_idx_q + CH_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d  = HOLD;
          cnt_d    = '0;
          ch_idx_d = '0;
          rst_no_d = '0;
          done_d   = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered outputs; rst_i clears everything immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      ch_idx_q <= '0;
      rst_no_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ch_idx_q <= ch_idx_d;
      rst_no_q <= rst_no_d;
      done_q   <= done_d;
    end
  end

  assign rst_no = rst_no_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer. Three instances with different
// parameter sets share the reset inputs. A timing model predicts each output
// from the number of edges since the sequence origin; literal checks pin the
// model at the key edges. Software-reset scenarios run when
// RESET_SEQ_SWRST_EN is defined.
module tb_reset_sequencer;

  localparam int NDUT = 3;
`ifdef RESET_SEQ_SWRST_EN
  localparam bit SW_EN = 1'b1;
`else
  localparam bit SW_EN = 1'b0;
`endif

  logic       clk      = 1'b0;
  logic       rst_i    = 1'b1;
  logic       sw_rst_i = 1'b0;
  logic [3:0] rn0;
  logic [0:0] rn1;
  logic [2:0] rn2;
  logic       d0, d1, d2;

  int errors = 0;
  int checks = 0;

  int p_n    [NDUT] = '{4, 1, 3};
  int p_sync [NDUT] = '{2, 3, 2};
  int p_hold [NDUT] = '{16, 1, 2};
  int p_stag [NDUT] = '{4, 4, 1};

  int r_cnt [NDUT];
  int k_cnt [NDUT];

  always #5 clk = ~clk;

  reset_sequencer u0 (
    .clk_i (clk), .rst_i (rst_i),
`ifdef RESET_SEQ_SWRST_EN
    .sw_rst_i (sw_rst_i),
`endif
    .rst_no (rn0), .done_o (d0)
  );

  reset_sequencer #(.NUM_CH(1), .SYNC_STAGES(3), .HOLD_CYCLES(1), .STAGGER_CYCLES(4)) u1 (
    .clk_i (clk), .rst_i (rst_i),
`ifdef RESET_SEQ_SWRST_EN
    .sw_rst_i (sw_rst_i),
`endif
    .rst_no (rn1), .done_o (d1)
  );

  reset_sequencer #(.NUM_CH(3), .SYNC_STAGES(2), .HOLD_CYCLES(2), .STAGGER_CYCLES(1)) u2 (
    .clk_i (clk), .rst_i (rst_i),
`ifdef RESET_SEQ_SWRST_EN
    .sw_rst_i (sw_rst_i),
`endif
    .rst_no (rn2), .done_o (d2)
  );

  // Model: r_cnt = edges since rst_i fell, k_cnt = edges since the sequence origin (1 at T0).
  always @(posedge clk or posedge rst_i) begin
    for (int d = 0; d < NDUT; d++) begin
      if (rst_i) begin
        r_cnt[d] <= 0;
        k_cnt[d] <= 0;
      end else begin
        if (r_cnt[d] < p_sync[d]) k_cnt[d] <= 0;
        else if (SW_EN && sw_rst_i) k_cnt[d] <= 0;
        else if (k_cnt[d] < 1000) k_cnt[d] <= k_cnt[d] + 1;
        if (r_cnt[d] < 1000) r_cnt[d] <= r_cnt[d] + 1;
      end
    end
  end

  // Expected {done, rst_no} : channel i is out of reset once k >= HOLD + i*STAGGER.
  function automatic logic [4:0] model_out(input int d);
    logic [4:0] e;
    e = 5'b00000;
    for (int i = 0; i < p_n[d]; i++) e[i] = (k_cnt[d] >= p_hold[d] + i * p_stag[d]);
    e[4] = (k_cnt[d] >= p_hold[d] + (p_n[d] - 1) * p_stag[d]);
    return e;
  endfunction

  function automatic logic [4:0] dut_out(input int d);
    case (d)
      0:       return {d0, rn0};
      1:       return {d1, 3'b000, rn1};
      default: return {d2, 1'b0, rn2};
    endcase
  endfunction

  task automatic check(input string nm, input int d, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d at %0t: got done/rst_no=%b expected %b", nm, d, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(posedge clk) begin
    #2;
    for (int d = 0; d < NDUT; d++) check("model", d, dut_out(d), model_out(d));
  end

  // Walk n edges from a restart; ta/tb = T0 edge index for SYNC=2 / SYNC=3 instances.
  task automatic seq(input int n, input int ta, input int tb);
    for (int e = 1; e <= n; e++) begin
      @(negedge clk);
      #1;
      if (e == ta + 14) check("u0_hold_end", 0, dut_out(0), 5'b00000);
      if (e == ta + 15) check("u0_ch0",      0, dut_out(0), 5'b00001);
      if (e == ta + 18) check("u0_gap",      0, dut_out(0), 5'b00001);
      if (e == ta + 19) check("u0_ch1",      0, dut_out(0), 5'b00011);
      if (e == ta + 23) check("u0_ch2",      0, dut_out(0), 5'b00111);
      if (e == ta + 26) check("u0_pre_done", 0, dut_out(0), 5'b00111);
      if (e == ta + 27) check("u0_done",     0, dut_out(0), 5'b11111);
      if (e == tb - 1)  check("u1_pre",      1, dut_out(1), 5'b00000);
      if (e == tb)      check("u1_t0",       1, dut_out(1), 5'b10001);
      if (e == ta)      check("u2_t0",       2, dut_out(2), 5'b00000);
      if (e == ta + 1)  check("u2_ch0",      2, dut_out(2), 5'b00001);
      if (e == ta + 2)  check("u2_ch1",      2, dut_out(2), 5'b00011);
      if (e == ta + 3)  check("u2_done",     2, dut_out(2), 5'b10111);
    end
  endtask

  task automatic all_zero(input string nm);
    for (int d = 0; d < NDUT; d++) check(nm, d, dut_out(d), 5'b00000);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    all_zero("reset_state");

    // Full sequence from power-on reset.
    rst_i = 1'b0;
    seq(35, 3, 4);

    // Reset again, then interrupt the sequence while u0 shows 0011.
    @(negedge clk);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    seq(23, 3, 4);
    check("u0_mid", 0, dut_out(0), 5'b00011);
    #1;
    rst_i = 1'b1;
    #1;
    all_zero("async_assert");
    @(negedge clk);
    rst_i = 1'b0;
    seq(35, 3, 4);

`ifdef RESET_SEQ_SWRST_EN
    // One-cycle software reset while in RUN.
    sw_rst_i = 1'b1;
    @(negedge clk);
    sw_rst_i = 1'b0;
    #1;
    all_zero("sw_pulse");
    seq(35, 1, 1);

    // Software reset held for 50 cycles.
    sw_rst_i = 1'b1;
    repeat (50) @(negedge clk);
    #1;
    all_zero("sw_held");
    sw_rst_i = 1'b0;
    seq(35, 1, 1);

    // Both resets high; hardware reset released first.
    rst_i    = 1'b1;
    sw_rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    all_zero("sw_after_hw");
    sw_rst_i = 1'b0;
    seq(35, 1, 1);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
